// File: rtl/cva5_types.sv
// Shared type and constant package for the core's small FIFO feeders.
package cva5_types;

    localparam int PACKER_CNT_W = 32;
    localparam int PACKER_BEATS = 4;

    typedef logic [PACKER_BEATS-1:0] packer_mask_t;

    function automatic logic [PACKER_CNT_W-1:0] packer_sat_inc(input logic [PACKER_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/fifo_beat_packer.sv
// Packs BEATS narrow beats into one wide FIFO word through an assembly/holding pair.
// Optional: define FIFO_PACKER_FLUSH_EN to let in_last close a partial word.
module fifo_beat_packer
    import cva5_types::*;
#(
    parameter int BEAT_W = 8,
    parameter int BEATS  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BEAT_W-1:0]       in_data,
    input  logic                    in_last,
    input  logic                    fifo_full,
    input  logic                    fifo_pop,
    output logic                    fifo_potential_push,
    output logic                    fifo_push,
    output logic [BEAT_W*BEATS-1:0] fifo_data_in,
    output logic [BEATS-1:0]        fifo_beat_mask,
    output logic [PACKER_CNT_W-1:0] words_pushed
);

    localparam int IDX_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WORD_W = BEAT_W * BEATS;

    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [WORD_W-1:0]       a_data_q, a_data_d;
    logic                    a_done_q, a_done_d;
    logic [WORD_W-1:0]       h_data_q, h_data_d;
    logic                    h_valid_q, h_valid_d;
    logic [PACKER_CNT_W-1:0] cnt_q, cnt_d;

    logic push, h_free, accept, xfer, last_lane, close;

    // Look-through: a pop in this cycle frees the slot we are about to write.
    assign push      = h_valid_q & (~fifo_full | fifo_pop);
    assign h_free    = ~h_valid_q | push;
    assign in_ready  = ~a_done_q | h_free;
    assign accept    = in_valid & in_ready;
    assign xfer      = a_done_q & h_free;
    assign last_lane = (idx_q == IDX_W'(BEATS - 1));

    assign fifo_push           = push;
    assign fifo_potential_push = push;
    assign fifo_data_in        = h_data_q;
    assign words_pushed        = cnt_q;

`ifdef FIFO_PACKER_FLUSH_EN
    logic [BEATS-1:0] a_mask_q, a_mask_d;
    logic [BEATS-1:0] h_mask_q, h_mask_d;

    assign close          = last_lane | in_last;
    assign fifo_beat_mask = h_mask_q;

    always_comb begin
        a_mask_d = a_mask_q;
        h_mask_d = h_mask_q;
        if (xfer) begin
            h_mask_d = a_mask_q;
            a_mask_d = '0;
        end
        if (accept) begin
            a_mask_d[idx_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_mask_q <= '0;
            h_mask_q <= '0;
        end else begin
            a_mask_q <= a_mask_d;
            h_mask_q <= h_mask_d;
        end
    end
`else
    logic unused_in_last;

    assign unused_in_last = in_last;
    assign close          = last_lane;
    assign fifo_beat_mask = {BEATS{push}};
`endif

    // Transfer is applied before the beat write so a same-cycle beat lands in a fresh lane 0.
    always_comb begin
        idx_d     = idx_q;
        a_data_d  = a_data_q;
        a_done_d  = a_done_q;
        h_data_d  = h_data_q;
        h_valid_d = h_valid_q;
        cnt_d     = push ? packer_sat_inc(cnt_q) : cnt_q;

        if (xfer) begin
            h_data_d  = a_data_q;
            h_valid_d = 1'b1;
            a_data_d  = '0;
            a_done_d  = 1'b0;
        end else if (push) begin
            h_valid_d = 1'b0;
        end

        if (accept) begin
            a_data_d[int'(idx_q)*BEAT_W +: BEAT_W] = in_data;
            if (close) begin
                a_done_d = 1'b1;
                idx_d    = '0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q     <= '0;
            a_data_q  <= '0;
            a_done_q  <= 1'b0;
            h_data_q  <= '0;
            h_valid_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            idx_q     <= idx_d;
            a_data_q  <= a_data_d;
            a_done_q  <= a_done_d;
            h_data_q  <= h_data_d;
            h_valid_q <= h_valid_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_beat_packer.sv
// Directed self-checking bench for fifo_beat_packer (BEAT_W=8, BEATS=4).
module tb_fifo_beat_packer;

    localparam int BW = 8;
    localparam int NB = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [BW-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic          fifo_full = 1'b0;
    logic          fifo_pop = 1'b0;
    logic          fifo_potential_push;
    logic          fifo_push;
    logic [BW*NB-1:0] fifo_data_in;
    logic [NB-1:0] fifo_beat_mask;
    logic [31:0]   words_pushed;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int stalls = 0;
    int last_cyc = 0;
    int b4 = 0, b8 = 0, b12 = 0;

    int           pcyc[$];
    logic [31:0]  pdata[$];
    logic [NB-1:0] pmask[$];

    fifo_beat_packer #(.BEAT_W(BW), .BEATS(NB)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .in_data             (in_data),
        .in_last             (in_last),
        .fifo_full           (fifo_full),
        .fifo_pop            (fifo_pop),
        .fifo_potential_push (fifo_potential_push),
        .fifo_push           (fifo_push),
        .fifo_data_in        (fifo_data_in),
        .fifo_beat_mask      (fifo_beat_mask),
        .words_pushed        (words_pushed)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && fifo_push) begin
            pcyc.push_back(cyc);
            pdata.push_back(fifo_data_in);
            pmask.push_back(fifo_beat_mask);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    endtask

    task automatic clear_log();
        pcyc.delete();
        pdata.delete();
        pmask.delete();
        stalls = 0;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        in_last   = 1'b0;
        fifo_full = 1'b0;
        fifo_pop  = 1'b0;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_log();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [BW-1:0] d, input logic last);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 20) begin
            stalls++;
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_timeout", 64'(in_ready), 64'd1);
        last_cyc = cyc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_push", 64'(fifo_push), 64'd0);
        check("rst_ppush", 64'(fifo_potential_push), 64'd0);
        check("rst_data", 64'(fifo_data_in), 64'd0);
        check("rst_mask", 64'(fifo_beat_mask), 64'd0);
        check("rst_words", 64'(words_pushed), 64'd0);

        // single word
        do_reset();
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        send(8'h44, 1'b0);
        idle(4);
        check("w1_count", 64'(pcyc.size()), 64'd1);
        if (pcyc.size() == 1) begin
            check("w1_latency", 64'(pcyc[0]), 64'(last_cyc + 2));
            check("w1_data", 64'(pdata[0]), 64'h44332211);
            check("w1_mask", 64'(pmask[0]), 64'hF);
        end
        check("w1_stalls", 64'(stalls), 64'd0);
        check("w1_words", 64'(words_pushed), 64'd1);

        // continuous stream of 12 beats
        do_reset();
        for (int i = 0; i < 12; i++) begin
            send(8'(i + 1), 1'b0);
            if (i == 3) b4 = last_cyc;
            if (i == 7) b8 = last_cyc;
            if (i == 11) b12 = last_cyc;
        end
        idle(4);
        check("st_count", 64'(pcyc.size()), 64'd3);
        if (pcyc.size() == 3) begin
            check("st_cyc0", 64'(pcyc[0]), 64'(b4 + 2));
            check("st_cyc1", 64'(pcyc[1]), 64'(b8 + 2));
            check("st_cyc2", 64'(pcyc[2]), 64'(b12 + 2));
            check("st_gap01", 64'(pcyc[1] - pcyc[0]), 64'd4);
            check("st_gap12", 64'(pcyc[2] - pcyc[1]), 64'd4);
            check("st_d0", 64'(pdata[0]), 64'h04030201);
            check("st_d1", 64'(pdata[1]), 64'h08070605);
            check("st_d2", 64'(pdata[2]), 64'h0C0B0A09);
        end
        check("st_stalls", 64'(stalls), 64'd0);
        check("st_words", 64'(words_pushed), 64'd3);

        // backpressure with look-through pop
        do_reset();
        fifo_full = 1'b1;
        for (int i = 0; i < 8; i++) send(8'(8'h21 + i), 1'b0);
        check("bp_stalls", 64'(stalls), 64'd0);
        idle(2);
        check("bp_ready_low", 64'(in_ready), 64'd0);
        check("bp_no_push", 64'(fifo_push), 64'd0);
        check("bp_log_empty", 64'(pcyc.size()), 64'd0);
        check("bp_held", 64'(fifo_data_in), 64'h24232221);
        fifo_pop = 1'b1;
        #1;
        check("bp_pop_push", 64'(fifo_push), 64'd1);
        check("bp_pop_ppush", 64'(fifo_potential_push), 64'd1);
        check("bp_pop_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        fifo_pop = 1'b0;
        #1;
        check("bp_after_push", 64'(fifo_push), 64'd0);
        check("bp_after_data", 64'(fifo_data_in), 64'h28272625);
        check("bp_after_ready", 64'(in_ready), 64'd1);
        fifo_full = 1'b0;
        idle(2);
        check("bp_count", 64'(pcyc.size()), 64'd2);
        if (pcyc.size() == 2) check("bp_d1", 64'(pdata[1]), 64'h28272625);
        check("bp_words", 64'(words_pushed), 64'd2);

        // in_last handling
        do_reset();
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b1);
`ifdef FIFO_PACKER_FLUSH_EN
        b4 = last_cyc;
        send(8'hCC, 1'b0);
        send(8'hDD, 1'b0);
        send(8'hEE, 1'b0);
        send(8'hFF, 1'b0);
        idle(4);
        check("fl_count", 64'(pcyc.size()), 64'd2);
        if (pcyc.size() == 2) begin
            check("fl_cyc", 64'(pcyc[0]), 64'(b4 + 2));
            check("fl_d0", 64'(pdata[0]), 64'h0000BBAA);
            check("fl_m0", 64'(pmask[0]), 64'h3);
            check("fl_d1", 64'(pdata[1]), 64'hFFEEDDCC);
            check("fl_m1", 64'(pmask[1]), 64'hF);
        end
`else
        idle(4);
        check("nf_no_push", 64'(pcyc.size()), 64'd0);
        check("nf_idle_mask", 64'(fifo_beat_mask), 64'd0);
        send(8'hCC, 1'b0);
        send(8'hDD, 1'b0);
        idle(3);
        check("nf_count", 64'(pcyc.size()), 64'd1);
        if (pcyc.size() == 1) begin
            check("nf_cyc", 64'(pcyc[0]), 64'(last_cyc + 2));
            check("nf_data", 64'(pdata[0]), 64'hDDCCBBAA);
            check("nf_mask", 64'(pmask[0]), 64'hF);
        end
`endif

        // asynchronous reset with a held word and a partial word
        do_reset();
        fifo_full = 1'b1;
        for (int i = 0; i < 6; i++) send(8'(8'h51 + i), 1'b0);
        fifo_pop = 1'b1;
        #1;
        check("ar_pre_push", 64'(fifo_push), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        check("ar_push_low", 64'(fifo_push), 64'd0);
        check("ar_data_zero", 64'(fifo_data_in), 64'd0);
        check("ar_ready", 64'(in_ready), 64'd1);
        fifo_pop  = 1'b0;
        fifo_full = 1'b0;
        idle(2);
        rst = 1'b0;
        clear_log();
        idle(4);
        check("ar_no_stale", 64'(pcyc.size()), 64'd0);
        check("ar_words", 64'(words_pushed), 64'd0);
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        send(8'h04, 1'b0);
        idle(3);
        check("ar_count", 64'(pcyc.size()), 64'd1);
        if (pcyc.size() == 1) begin
            check("ar_data", 64'(pdata[0]), 64'h04030201);
            check("ar_mask", 64'(pmask[0]), 64'hF);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fifo_beat_packer.md
Name: fifo_beat_packer

Overview:
- Upstream feeder for the core's small FIFOs.
- Accepts narrow beats on a valid/ready handshake and packs BEATS beats into one wide word.
- Drives the FIFO's potential_push / push / data_in, using the FIFO's full and pop for look-through, so it can push every cycle even when the FIFO is full.
- Double-buffered (assembly register A plus holding register H), so a word is sustained every BEATS cycles.

Parameters:
- BEAT_W, 8, width of one input beat in bits.
- BEATS, 4, beats per packed word; legal range is 2 or more.
- IDX_W, $clog2(BEATS), lane index width (derived, not overridable).

Ports:
- clk  input  1  core clock.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  beat offered.
- in_ready  output  1  beat accepted when in_valid & in_ready.
- in_data  input  BEAT_W  beat payload.
- in_last  input  1  close the current word after this beat (flush; see Optional Feature).
- fifo_full  input  1  downstream FIFO full.
- fifo_pop  input  1  downstream FIFO popping this cycle.
- fifo_potential_push  output  1  write strobe to the FIFO storage.
- fifo_push  output  1  FIFO occupancy advance.
- fifo_data_in  output  BEAT_W*BEATS  packed word; lane k sits at bits [k*BEAT_W +: BEAT_W], and lane 0 is the first beat.
- fifo_beat_mask  output  BEATS  valid-lane mask of the pushed word.
- words_pushed  output  32  saturating count of pushes.

Behaviour:
- Reset (async assert): the following are cleared.
  - A lanes, lane index idx, a_done, H contents, h_valid, h_mask, words_pushed all go to 0.
  - Outputs: in_ready=1, fifo_push=0, fifo_potential_push=0, fifo_data_in=0, fifo_beat_mask=0.
- Reset mid-operation discards any partial word or held word with no push.
- Push rule (combinational):
  - push = h_valid & (~fifo_full | fifo_pop).
  - fifo_potential_push = push.
  - fifo_data_in = H; fifo_beat_mask = h_mask.
  - Never assert push while full unless pop is asserted in the same cycle.
- h_free = ~h_valid | push.
- in_ready = ~a_done | h_free (combinational).
- Accepted beat:
  - Writes lane idx of A and sets a_mask[idx].
  - If idx==BEATS-1, or in_last with flush enabled: set a_done and set idx to 0.
  - Otherwise idx increments.
- Transfer: when a_done & h_free at a clock edge:
  - H <= A, h_mask <= a_mask, h_valid <= 1.
  - A mask clears and a_done clears.
  - A beat accepted in the same cycle writes lane 0 of the fresh A; this gives no bubble.
- h_valid clears on push unless a transfer occurs in the same cycle.
- Latency: the final beat accepted at cycle t produces fifo_push at cycle t+2 earliest (t+1 registers a_done, t+2 registers H... push combinational off H).
  - Steady state throughput is 1 word per BEATS accepted beats.
- Backpressure:
  - FIFO full without pop: H holds and A may complete; in_ready then drops.
  - The first pop re-enables push in that same cycle; in_ready rises in that same cycle through h_free.
- Unfilled lanes of a partial word are 0 in data and 0 in the mask.
- words_pushed increments on push and saturates at 2^32-1.

Optional Feature:
- Macro: FIFO_PACKER_FLUSH_EN.
- Defined: in_last closes a partial word; fifo_beat_mask reports the valid lanes.
- Undefined:
  - in_last is ignored.
  - Words close only when all BEATS lanes are filled.
  - fifo_beat_mask is constant all-ones whenever push is asserted and 0 otherwise.
  - Mask flops are removed.

Decomposition:
- Shared package cva5_types gets typedef packer_mask_t (logic [BEATS-1:0]) and localparam PACKER_CNT_W = 32.
- No sub-module is warranted. The lane index counter and the two registers are inline.
- The FIFO itself is instantiated by the parent, not here.

Test Plan:
- Conditions: BEAT_W=8, BEATS=4, FIFO never full.
  - Stimulus: beats 0x11,0x22,0x33,0x44 on consecutive cycles.
  - Response: one push 2 cycles after 0x44 with fifo_data_in=0x44332211 and mask=4'b1111; in_ready stays 1.
- Conditions: continuous stream of 12 beats.
  - Response: 3 pushes spaced exactly 4 cycles apart; in_ready never deasserts; words_pushed=3.
- Conditions: fifo_full=1, fifo_pop=0 held; feed 8 beats.
  - Response: first word held with push=0; in_ready drops after the 8th beat.
  - Then pulse fifo_pop one cycle: push=1 in that cycle; in_ready=1 in that cycle.
- Conditions: FLUSH_EN defined; beats 0xAA then 0xBB with in_last.
  - Response: push data=0x0000BBAA, mask=4'b0011.
  - Next beat lands in lane 0.
- Conditions: FLUSH_EN undefined; same stimulus as the previous scenario.
  - Response: no push until 2 more beats arrive; mask=4'b1111.
- Conditions: assert rst asynchronously mid-word after 2 beats and with H valid.
  - Response: push=0 immediately; no stale word is pushed after release.
  - The next 4 beats form a clean word starting at lane 0.
